// File: rtl/frame_encode_multi.sv
// ISO/IEC 14443-3A Tx frame encoder: serialises source bits, with optional per-byte
// parity and an N-byte CRC (LSByte/LSbit first), plus abort, busy and a bit counter.
module frame_encode_multi #(
   parameter int CRC_BYTES  = 2,
   parameter bit ODD_PARITY = 1'b1,
   parameter int CNT_W      = 16,
   localparam int CRC_W     = (CRC_BYTES > 0) ? 8 * CRC_BYTES : 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fdt_trigger,
   input  logic             parity_en,
   input  logic             append_crc,
   input  logic [CRC_W-1:0] crc,
   input  logic             abort,
   input  logic             in_data,
   input  logic             in_data_valid,
   input  logic             in_last_bit_in_byte,
   output logic             in_req,
   output logic             out_data,
   output logic             out_data_valid,
   output logic             out_last_bit_in_byte,
   input  logic             out_req,
   output logic             busy,
   output logic [CNT_W-1:0] bit_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_DATA, S_PARITY, S_CRC, S_CRC_PARITY, S_END
   } state_t;

   state_t           state;
   logic             par_en_q;
   logic             par_acc;
   logic [CRC_W-1:0] crc_sr;
   logic [2:0]       crc_idx;
   logic [3:0]       bits_rem;
   logic [CRC_W-1:0] crc_src;
   logic             crc_go;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // At a byte boundary the next CRC byte comes from the input (first byte) or the
   // shift register, which already holds the remaining bytes LSByte-aligned.
   always_comb begin
      crc_src = (state == S_PARITY) ? crc : crc_sr;
      if (state == S_PARITY)
         crc_go = append_crc && (CRC_BYTES > 0);
      else
         crc_go = (int'(crc_idx) < CRC_BYTES - 1);
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= S_IDLE;
         in_req               <= 1'b0;
         out_data             <= 1'b0;
         out_data_valid       <= 1'b0;
         out_last_bit_in_byte <= 1'b0;
         bit_count            <= '0;
      end else begin
         in_req <= 1'b0;
         if (abort && state != S_IDLE) begin
            state                <= S_IDLE;
            out_data_valid       <= 1'b0;
            out_last_bit_in_byte <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (fdt_trigger && in_data_valid) begin
                     out_data             <= in_data;
                     out_data_valid       <= 1'b1;
                     out_last_bit_in_byte <= in_last_bit_in_byte && !parity_en;
                     in_req               <= 1'b1;
                     bit_count            <= CNT_W'(1);
                     par_en_q             <= parity_en;
                     par_acc              <= ODD_PARITY ^ in_data;
                     state                <= in_last_bit_in_byte ? S_PARITY : S_DATA;
                  end
               end
               S_DATA: begin
                  if (out_req) begin
                     out_data             <= in_data;
                     out_last_bit_in_byte <= in_last_bit_in_byte && !par_en_q;
                     par_acc              <= par_acc ^ in_data;
                     in_req               <= 1'b1;
                     bit_count            <= sat_inc(bit_count);
                     if (in_last_bit_in_byte) state <= S_PARITY;
                  end
               end
               S_PARITY, S_CRC_PARITY: begin
                  if (out_req) begin
                     if (par_en_q) begin
                        out_data             <= par_acc;
                        out_last_bit_in_byte <= 1'b1;
                        bit_count            <= sat_inc(bit_count);
                     end
                     // Without parity there is no boundary bit, so the next byte's
                     // first bit goes out on this same request.
                     if (state == S_PARITY && in_data_valid) begin
                        state   <= S_DATA;
                        par_acc <= ODD_PARITY;
                        if (!par_en_q) begin
                           out_data             <= in_data;
                           out_last_bit_in_byte <= in_last_bit_in_byte;
                           par_acc              <= ODD_PARITY ^ in_data;
                           in_req               <= 1'b1;
                           bit_count            <= sat_inc(bit_count);
                           if (in_last_bit_in_byte) state <= S_PARITY;
                        end
                     end else if (crc_go) begin
                        state    <= S_CRC;
                        crc_sr   <= crc_src;
                        crc_idx  <= (state == S_PARITY) ? 3'd0 : crc_idx + 3'd1;
                        bits_rem <= 4'd8;
                        par_acc  <= ODD_PARITY;
                        if (!par_en_q) begin
                           out_data             <= crc_src[0];
                           out_last_bit_in_byte <= 1'b0;
                           crc_sr               <= crc_src >> 1;
                           bits_rem             <= 4'd7;
                           par_acc              <= ODD_PARITY ^ crc_src[0];
                           bit_count            <= sat_inc(bit_count);
                        end
                     end else if (par_en_q) begin
                        state <= S_END;
                     end else begin
                        state                <= S_IDLE;
                        out_data_valid       <= 1'b0;
                        out_last_bit_in_byte <= 1'b0;
                     end
                  end
               end
               S_CRC: begin
                  if (out_req) begin
                     out_data             <= crc_sr[0];
                     out_last_bit_in_byte <= (bits_rem == 4'd1) && !par_en_q;
                     crc_sr               <= crc_sr >> 1;
                     par_acc              <= par_acc ^ crc_sr[0];
                     bits_rem             <= bits_rem - 4'd1;
                     bit_count            <= sat_inc(bit_count);
                     if (bits_rem == 4'd1) state <= S_CRC_PARITY;
                  end
               end
               S_END: begin
                  if (out_req) begin
                     state                <= S_IDLE;
                     out_data_valid       <= 1'b0;
                     out_last_bit_in_byte <= 1'b0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
